// File: rtl/exec_sequencer.sv
// rtl/exec_sequencer.sv - multi-cycle ALU/LDI instruction sequencer over an external register file and ALU
// Optional feature macro: EXEC_SEQ_SKIP_DUP_EN (skip the second operand read when rs1 == rs2).
module exec_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    output logic [2:0]  rf_addr,
    output logic        rf_we,
    output logic [7:0]  rf_wdata,
    input  logic [7:0]  rf_rdata,
    output logic [7:0]  alu_opcode,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    input  logic [7:0]  alu_out,
    input  logic [7:0]  alu_flags,
    output logic [7:0]  eflags,
    output logic [7:0]  pc,
    output logic        done,
    output logic        illegal,
    output logic        busy
);

    localparam logic [1:0] CLS_ALU = 2'b00;
    localparam logic [1:0] CLS_LDI = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_OP1,
        S_RD_OP2,
        S_EXEC,
        S_WB,
        S_ERR
    } state_t;

    state_t      state;
    state_t      state_n;
    logic [15:0] ir;
    logic [7:0]  op1;
    logic [7:0]  op2;
    logic [7:0]  result;
    logic        accept;
    logic        skip_dup;

    logic [2:0]  ir_rd;
    logic [2:0]  ir_rs1;
    logic [2:0]  ir_rs2;
    logic [4:0]  ir_op;
    logic        unused_ir_cls;

    assign ir_rd         = ir[13:11];
    assign ir_rs1        = ir[10:8];
    assign ir_rs2        = ir[7:5];
    assign ir_op         = ir[4:0];
    // Class is decoded from instr at accept time; the latched copy is kept whole but not re-read.
    assign unused_ir_cls = ^ir[15:14];

    assign accept = instr_valid && (state == S_IDLE);

`ifdef EXEC_SEQ_SKIP_DUP_EN
    assign skip_dup = (ir_rs1 == ir_rs2);
`else
    assign skip_dup = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            ir     <= 16'h0000;
            pc     <= 8'h00;
            op1    <= 8'h00;
            op2    <= 8'h00;
            result <= 8'h00;
            eflags <= 8'h00;
        end else begin
            state <= state_n;
            if (accept) begin
                ir <= instr;
                pc <= pc + 8'd1;
                if (instr[15:14] == CLS_LDI) begin
                    result <= instr[7:0];
                end
            end
            case (state)
                S_RD_OP1: begin
                    op1 <= rf_rdata;
                    if (skip_dup) begin
                        op2 <= rf_rdata;
                    end
                end
                S_RD_OP2: op2 <= rf_rdata;
                S_EXEC: begin
                    result <= alu_out;
                    eflags <= alu_flags;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (instr_valid) begin
                    case (instr[15:14])
                        CLS_ALU: state_n = S_RD_OP1;
                        CLS_LDI: state_n = S_WB;
                        default: state_n = S_ERR;
                    endcase
                end
            end
            S_RD_OP1: state_n = skip_dup ? S_EXEC : S_RD_OP2;
            S_RD_OP2: state_n = S_EXEC;
            S_EXEC:   state_n = S_WB;
            S_WB:     state_n = S_IDLE;
            S_ERR:    state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    // Outputs depend only on state and registers, never on instr/instr_valid.
    always_comb begin
        instr_ready = 1'b0;
        busy        = 1'b1;
        rf_addr     = 3'd0;
        rf_we       = 1'b0;
        done        = 1'b0;
        illegal     = 1'b0;
        case (state)
            S_IDLE: begin
                instr_ready = 1'b1;
                busy        = 1'b0;
            end
            S_RD_OP1: rf_addr = ir_rs1;
            S_RD_OP2: rf_addr = ir_rs2;
            S_WB: begin
                rf_addr = ir_rd;
                rf_we   = 1'b1;
                done    = 1'b1;
            end
            S_ERR: illegal = 1'b1;
            default: ;
        endcase
    end

    assign rf_wdata   = result;
    assign alu_a      = op1;
    assign alu_b      = op2;
    assign alu_opcode = {3'b000, ir_op};

endmodule

// File: doc/exec_sequencer.md
EXEC_SEQUENCER -- requirements
Module: exec_sequencer

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 instr  input  16  instruction word: [15:14] class (00 ALU, 01 LDI, 10/11 illegal), [13:11] rd, [10:8] rs1, [7:5] rs2, [4:0] alu op, [7:0] LDI immediate.
REQ-004 instr_valid  input  1  instr is valid this cycle.
REQ-005 instr_ready  output  1  sequencer can accept an instruction.
REQ-006 rf_addr  output  3  register-file port address.
REQ-007 rf_we  output  1  register-file write enable.
REQ-008 rf_wdata  output  8  register-file write data.
REQ-009 rf_rdata  input  8  register-file read data; combinational read of rf_addr.
REQ-010 alu_opcode  output  8  ALU opcode, {3'b000, op[4:0]}.
REQ-011 alu_a, alu_b  output  8 each  ALU operands.
REQ-012 alu_out, alu_flags  input  8 each  ALU result and flags; combinational.
REQ-013 eflags  output  8  last latched ALU flags.
REQ-014 pc  output  8  accepted-instruction counter.
REQ-015 done  output  1  one-cycle pulse in the write-back cycle.
REQ-016 illegal  output  1  one-cycle pulse on an illegal class.
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 States: IDLE, RD_OP1, RD_OP2, EXEC, WB, ERR; all outputs are decoded from the state and internal registers only, with no combinational path from instr or instr_valid to any output.
REQ-019 instr_ready = 1 only in IDLE; an instruction is accepted on a clk edge where instr_valid && instr_ready, and instr is latched whole.
REQ-020 Each accept increments pc by 1, modulo 256 (255 -> 0); no other event changes pc.
REQ-021 ALU class: IDLE -> RD_OP1 -> RD_OP2 -> EXEC -> WB -> IDLE, five cycles from accept to return to IDLE.
REQ-022 RD_OP1: rf_addr = rs1, and rf_rdata is latched into op1 at the end of the cycle.
REQ-023 RD_OP2: rf_addr = rs2, and rf_rdata is latched into op2 at the end of the cycle.
REQ-024 EXEC: alu_a = op1 and alu_b = op2; at the end of the cycle alu_out is latched into result and alu_flags into eflags.
REQ-025 WB: rf_we = 1, rf_addr = rd, rf_wdata = result, done = 1.
REQ-026 LDI class: IDLE -> WB -> IDLE; result = imm; eflags unchanged.
REQ-027 Illegal class: IDLE -> ERR -> IDLE; illegal = 1 in ERR; no register write; pc still increments.
REQ-028 rf_we = 0 in all states except WB.
REQ-029 Outside EXEC, alu_a and alu_b hold op1 and op2, and alu_opcode holds the latched op.
REQ-030 Outside RD_OP1, RD_OP2 and WB, rf_addr = 0 and rf_wdata = result.
REQ-031 rd equal to rs1 or rs2 is legal; the operands are read before the write, so the old value is used.
REQ-032 instr_valid while busy is ignored, and the instruction is not consumed.

Reset
REQ-033 While rst is asserted at a clk edge: state goes to IDLE; pc, op1, op2, result and eflags go to 0; the latched instruction goes to 0.
REQ-034 In the cycle after a reset edge, rf_we = 0, done = 0, illegal = 0, busy = 0 and instr_ready = 1.
REQ-035 Reset in any state, mid-instruction included, aborts the instruction with no register write.
REQ-036 rst has priority over an accept on the same edge.

Configuration
REQ-037 Macro EXEC_SEQ_SKIP_DUP_EN; with it defined, an ALU instruction with rs1 == rs2 goes RD_OP1 -> EXEC, op2 is loaded with the same rf_rdata as op1, and latency is 4 cycles.
REQ-038 Without EXEC_SEQ_SKIP_DUP_EN, every ALU instruction visits RD_OP2 (5 cycles).

Verification
REQ-039 Reset, then LDI rd=3 imm=0x5A with valid held -> accept at edge 1; WB next cycle with rf_we=1, rf_addr=3, rf_wdata=0x5A, done=1; pc=1; eflags=0.
REQ-040 ALU rd=2 rs1=3 rs2=4 op=0x01, bench regfile r3=0x10, r4=0x22 -> rf_addr sequence 3, 4; alu_a=0x10 and alu_b=0x22 in EXEC; write of model alu_out to r2 in cycle 5; eflags = model flags.
REQ-041 ALU rs1=rs2=5 -> 5-cycle flow without the macro and 4-cycle flow with it; alu_a = alu_b in EXEC.
REQ-042 Class 11 accepted -> illegal pulses 1 cycle, no rf_we, pc incremented, instr_ready back to 1 after 2 cycles.
REQ-043 rst asserted in EXEC -> no WB; next cycle rf_we=0, busy=0, pc=0; a following instruction completes normally.
REQ-044 256 LDI instructions back-to-back -> pc wraps to 0; instr_ready low in every WB cycle; no instruction is lost or duplicated.
